dff_chain_error_counter: RTL

//  Stimulus/checker stage directly upstream of the serial error-count output block.
//  - Drives a toggle pattern into NUM_CHAINS DFF chains on the 12nm DUT.
//  - Compares each returned chain output against the delayed expected pattern.
//  - Keeps one saturating CNT_W-bit mismatch counter per chain.
//  - Every WINDOW compare cycles, pulses save_data so the output stage snapshots the counts.

---
 rtl/dff_chain_error_counter_if.sv | 37 +++
 rtl/dff_chain_error_counter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dff_chain_error_counter_if.sv
// Bundles the pattern/compare signals between the chain checker and its
// environment: run controls and returned chain bits in, pattern bit,
// snapshot strobe and per-chain error counts out.
interface dff_chain_error_counter_if #(
    parameter int NUM_CHAINS = 10,
    parameter int CNT_W      = 12
);
    logic                        enable;
    logic                        clear_cnt;
    logic [NUM_CHAINS-1:0]       chain_out;
    logic                        chain_in;
    logic                        save_data;
    logic [NUM_CHAINS*CNT_W-1:0] error_cnt;
    logic                        running;

    // Environment side: drives controls and the raw chain outputs.
    modport master (
        output enable,
        output clear_cnt,
        output chain_out,
        input  chain_in,
        input  save_data,
        input  error_cnt,
        input  running
    );

    // Checker side.
    modport slave (
        input  enable,
        input  clear_cnt,
        input  chain_out,
        output chain_in,
        output save_data,
        output error_cnt,
        output running
    );
endinterface

// File: rtl/dff_chain_error_counter.sv
// DFF chain stimulus/checker. Drives a toggle pattern into all chains,
// compares each returned chain against the pattern delayed by the chain
// round-trip latency, keeps a saturating mismatch count per chain and
// strobes save_data once per compare window so the output stage can
// snapshot the counts.
module dff_chain_error_counter #(
    parameter int NUM_CHAINS    = 10,
    parameter int CNT_W         = 12,
    parameter int PIPE_LAT      = 64,
    parameter int WINDOW        = 1000000,
    parameter bit CLEAR_ON_SAVE = 1'b1
) (
    input logic                  data_clk,
    input logic                  reset,
    dff_chain_error_counter_if.slave bus
);

    localparam int WIN_W  = (WINDOW > 1)   ? $clog2(WINDOW)   : 1;
    localparam int FILL_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_SAVE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic [WIN_W-1:0]      win_q, win_d;
    logic                  p_q, p_d;
    logic [PIPE_LAT-1:0]   exp_q;
    logic [NUM_CHAINS-1:0] chain_out_q;
    logic [CNT_W-1:0]      cnt_q [NUM_CHAINS];
    logic [CNT_W-1:0]      cnt_d [NUM_CHAINS];
    logic                  compare_en;
    logic                  clear_all;
    logic                  exp_bit;
    logic [NUM_CHAINS*CNT_W-1:0] cnt_flat;

    // Increment that sticks at full scale instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // Expected bit: the pattern as it should emerge from chain_out_q.
    assign exp_bit = exp_q[PIPE_LAT-1];

    // State, fill/window counters and pattern bit.
    always_ff @(posedge data_clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            fill_q  <= '0;
            win_q   <= '0;
            p_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            win_q   <= win_d;
            p_q     <= p_d;
        end
    end

    // Next state: fill the chains, run a window of compares, one-cycle
    // snapshot, then straight back to compares; enable low always idles.
    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        win_d      = win_q;
        p_d        = p_q;
        compare_en = 1'b0;
        clear_all  = 1'b0;
        if (!bus.enable) begin
            state_d = S_IDLE;
            fill_d  = '0;
            win_d   = '0;
            p_d     = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_FILL;
                    fill_d  = '0;
                    win_d   = '0;
                    p_d     = 1'b0;
                end
                S_FILL: begin
                    p_d = ~p_q;
                    if (fill_q == FILL_LAST) begin
                        state_d = S_RUN;
                        fill_d  = '0;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                S_RUN: begin
                    p_d        = ~p_q;
                    compare_en = 1'b1;
                    if (win_q == WIN_LAST) begin
                        state_d = S_SAVE;
                        win_d   = '0;
                    end else begin
                        win_d = win_q + WIN_W'(1);
                    end
                end
                S_SAVE: begin
                    p_d       = ~p_q;
                    state_d   = S_RUN;
                    win_d     = '0;
                    clear_all = CLEAR_ON_SAVE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Expected-pattern delay line and the input register on the returned chains;
    // both are part of the same round-trip latency so they stay aligned.
    always_ff @(posedge data_clk or negedge reset) begin
        if (!reset) begin
            exp_q       <= '0;
            chain_out_q <= '0;
        end else begin
            exp_q       <= PIPE_LAT'({exp_q, p_q});
            chain_out_q <= bus.chain_out;
        end
    end

    // Per-chain count update: explicit clear beats everything, otherwise
    // count a mismatch only while comparing.
    always_comb begin
        for (int k = 0; k < NUM_CHAINS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (bus.clear_cnt || clear_all) begin
                cnt_d[k] = '0;
            end else if (compare_en && (chain_out_q[k] != exp_bit)) begin
                cnt_d[k] = sat_inc(cnt_q[k]);
            end
        end
    end

    // Error counters.
    always_ff @(posedge data_clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CHAINS; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CHAINS; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // Flatten counters onto the output bus, chain k at [k*CNT_W +: CNT_W].
    always_comb begin
        cnt_flat = '0;
        for (int k = 0; k < NUM_CHAINS; k++) begin
            cnt_flat[k*CNT_W +: CNT_W] = cnt_q[k];
        end
    end

    assign bus.error_cnt = cnt_flat;
    assign bus.chain_in  = p_q;
    assign bus.running   = (state_q == S_RUN) || (state_q == S_SAVE);
    // Strobe is suppressed as soon as enable drops.
    assign bus.save_data = (state_q == S_SAVE) && bus.enable;

endmodule
